pixel_writer: RTL
=================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001: Parameter WIDTH, default 320, frame width in pixels.
REQ-002: Parameter HEIGHT, default 240, frame height in pixels.
REQ-003: Parameter FRAC, default 6, fractional bits of the Q10.6 input coordinates.
REQ-004: Parameter DEPTH, default 4, write-FIFO entries (power of two).
REQ-005: CLK  input  1  single clock, all logic on its rising edge.
REQ-006: RST  input  1  reset, synchronous and active-high.
REQ-007: START  input  1  high in the cycle carrying bit 15 (MSB) of a pixel word on PX/PY/C.
REQ-008: PX  input  1  serial pixel x, signed Q10.6, MSB first.
REQ-009: PY  input  1  serial pixel y, signed Q10.6, MSB first.
REQ-010: C  input  1  serial 16-bit colour, MSB first.
REQ-011: VALID  input  1  sampled with START; 1 = pixel inside triangle.
REQ-012: TRI_DONE  input  1  one-cycle pulse, rasterizer finished current triangle.
REQ-013: MEM_ADDR  output  17  linear framebuffer address, y*WIDTH + x.
REQ-014: MEM_DATA  output  16  colour to write.
REQ-015: MEM_WE  output  1  write request; high while FIFO non-empty.
REQ-016: MEM_READY  input  1  memory accepts the write this cycle.
REQ-017: TRI_ACK  output  1  one-cycle pulse, all pixels of the triangle written.
REQ-018: DROP_CNT  output  8  saturating count of pixels lost to FIFO overflow.

Function
REQ-019: Deserializer SHALL have states IDLE and SHIFT; START in any state loads bit 15 on all three lines, latches VALID, enters SHIFT with bit counter 14.
REQ-020: In SHIFT, each cycle SHALL shift one bit per line and decrement the counter; after bit 0 is sampled the word is complete and state returns to IDLE.
REQ-021: START during SHIFT SHALL abort the partial word (discarded, not counted) and begin a new one.
REQ-022: On the edge following bit-0 sampling, a completed word SHALL be evaluated: x = PX_word >>> FRAC, y = PY_word >>> FRAC (arithmetic).
REQ-023: Word SHALL be pushed only if latched VALID=1 and 0 <= x < WIDTH and 0 <= y < HEIGHT; otherwise silently discarded (not counted).
REQ-024: FIFO entry SHALL hold {y*WIDTH + x (17 bits), colour (16 bits)}; address computed before push.
REQ-025: Pushed entry SHALL appear on MEM_ADDR/MEM_DATA with MEM_WE=1 in the cycle after the push edge when FIFO was empty.
REQ-026: Entry SHALL pop on a rising edge where MEM_WE=1 and MEM_READY=1; MEM_ADDR/MEM_DATA held stable while MEM_WE=1 and MEM_READY=0.
REQ-027: Push and pop in the same cycle SHALL both occur, occupancy unchanged, including when full.
REQ-028: Push to a full FIFO with no simultaneous pop SHALL discard the word and increment DROP_CNT, saturating at 255.
REQ-029: Read/write pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-030: TRI_DONE SHALL set a pending flag; TRI_ACK pulses exactly one cycle when pending=1, deserializer IDLE, no evaluation in flight, and FIFO empty; pending then clears.
REQ-031: TRI_DONE arriving while pending=1 SHALL merge into one TRI_ACK.
REQ-032: TRI_DONE coincident with a word's final evaluation SHALL wait until that word is written or discarded.

Reset
REQ-033: RST=1 at an edge SHALL clear deserializer to IDLE, FIFO pointers, pending flag and DROP_CNT, discarding any partial word and queued entries.
REQ-034: After reset, MEM_WE=0, TRI_ACK=0, DROP_CNT=0, MEM_ADDR=0, MEM_DATA=0.
REQ-035: RST SHALL override START, TRI_DONE and MEM_READY in the same cycle.

Verification
REQ-036: Word x=0x0280 (10.0), y=0x0140 (5.0), C=0xF800, VALID=1, MEM_READY=1 -> single write MEM_ADDR=1610, MEM_DATA=0xF800, MEM_WE high one cycle.
REQ-037: Words with VALID=0; x=0xFFC0 (-1); x=0x5000 (320); y=0x3C00 (240) -> no MEM_WE, DROP_CNT stays 0.
REQ-038: MEM_READY=0, six valid back-to-back words -> FIFO holds 4, DROP_CNT=2; raise MEM_READY -> first 4 written in order, then MEM_WE=0.
REQ-039: START re-asserted 8 cycles into a word -> first word discarded, second written correctly.
REQ-040: TRI_DONE with 3 entries queued and MEM_READY toggling -> TRI_ACK pulses once, one cycle after last pop edge; none earlier.
REQ-041: RST asserted with 2 entries queued and a word mid-shift -> next cycle MEM_WE=0, DROP_CNT=0, no TRI_ACK; subsequent word written normally.

Source files
------------

// File: rtl/pixel_writer.sv
// Serial pixel deserializer feeding a small write FIFO toward a linear framebuffer,
// with triangle-completion handshake once every accepted pixel has been written.
module pixel_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int FRAC   = 6,
  parameter int DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        PX,
  input  logic        PY,
  input  logic        C,
  input  logic        VALID,
  input  logic        TRI_DONE,
  output logic [16:0] MEM_ADDR,
  output logic [15:0] MEM_DATA,
  output logic        MEM_WE,
  input  logic        MEM_READY,
  output logic        TRI_ACK,
  output logic [7:0]  DROP_CNT
);

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W1 = PTR_W + 1;
  localparam int unsigned DROP_W = 8;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   px_q, px_d, py_q, py_d, c_q, c_d;
  logic                vld_q, vld_d;
  logic                eval_q, eval_d;
  logic [PTR_W:0]      wr_q, wr_d, rd_q, rd_d;
  entry_t              head_q, head_d;
  logic                we_q, we_d;
  logic                pend_q, pend_d;
  logic                ack_q, ack_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  entry_t              mem_q [DEPTH];

  logic signed [WORD_W-1:0] x_s, y_s;
  logic   in_range_c, ok_c, full_c, pop_c, push_c, drop_c, ack_c;
  entry_t new_entry;

  // Word evaluation: integer pixel coordinates, bounds test and linear address.
  always_comb begin
    x_s        = $signed(px_q) >>> FRAC;
    y_s        = $signed(py_q) >>> FRAC;
    in_range_c = (int'(x_s) >= 0) && (int'(x_s) < WIDTH) &&
                 (int'(y_s) >= 0) && (int'(y_s) < HEIGHT);
    new_entry.addr = ADDR_W'(int'(y_s) * WIDTH + int'(x_s));
    new_entry.data = c_q;
    ok_c       = eval_q && vld_q && in_range_c;
  end

  // FIFO control; a push into a full FIFO only survives if the head pops in the same edge.
  always_comb begin
    full_c = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    pop_c  = we_q && MEM_READY;
    push_c = ok_c && (!full_c || pop_c);
    drop_c = ok_c && full_c && !pop_c;
    wr_d   = wr_q + PTR_W1'(push_c);
    rd_d   = rd_q + PTR_W1'(pop_c);
    we_d   = (wr_d != rd_d);
    if (!we_d) begin
      head_d = '0;
    end else if (push_c && (rd_d[PTR_W-1:0] == wr_q[PTR_W-1:0])) begin
      head_d = new_entry;
    end else begin
      head_d = mem_q[rd_d[PTR_W-1:0]];
    end
    drop_d = (drop_c && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
  end

  // Triangle handshake: a single ack once nothing of the triangle remains anywhere in the pipe.
  always_comb begin
    ack_c  = pend_q && (state_q == S_IDLE) && !eval_q && !we_q;
    ack_d  = ack_c;
    pend_d = ack_c ? 1'b0 : (pend_q || TRI_DONE);
  end

  // Deserializer; START always restarts, dropping any partial word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    px_d    = px_q;
    py_d    = py_q;
    c_d     = c_q;
    vld_d   = vld_q;
    eval_d  = 1'b0;
    if (START) begin
      state_d = S_SHIFT;
      cnt_d   = CNT_W'(14);
      px_d    = {15'b0, PX};
      py_d    = {15'b0, PY};
      c_d     = {15'b0, C};
      vld_d   = VALID;
    end else if (state_q == S_SHIFT) begin
      px_d = {px_q[WORD_W-2:0], PX};
      py_d = {py_q[WORD_W-2:0], PY};
      c_d  = {c_q[WORD_W-2:0], C};
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        eval_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      c_q     <= '0;
      vld_q   <= 1'b0;
      eval_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      c_q     <= c_d;
      vld_q   <= vld_d;
      eval_q  <= eval_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push_c) begin
      mem_q[wr_q[PTR_W-1:0]] <= new_entry;
    end
  end

  assign MEM_ADDR = head_q.addr;
  assign MEM_DATA = head_q.data;
  assign MEM_WE   = we_q;
  assign TRI_ACK  = ack_q;
  assign DROP_CNT = drop_q;

endmodule
